// File: rtl/foo_pkg.sv
// Shared widths, operand payload type and pointer helper for the foo operand feeder.
package foo_pkg;

  localparam int unsigned FOO_WIDTH = 5;
  localparam int unsigned FOO_NREQ  = 3;
  localparam int unsigned FOO_DEPTH = 2;
  localparam int unsigned FOO_SRC_W = 2;
  localparam int unsigned FOO_CNT_W = 2;

  typedef struct packed {
    logic [1:0]           src;
    logic [FOO_WIDTH-1:0] in2;
    logic [FOO_WIDTH-1:0] in1;
  } foo_operand_t;

  // Next round-robin start position after requester idx wins.
  function automatic logic [FOO_SRC_W-1:0] foo_wrap_inc(input logic [FOO_SRC_W-1:0] idx);
    logic [FOO_SRC_W-1:0] nxt;
    if (idx == FOO_SRC_W'(FOO_NREQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + FOO_SRC_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/foo_fifo2.sv
// Two-entry register FIFO of operand payloads; head and count come straight from flops.
module foo_fifo2
  import foo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  foo_operand_t         push_data,
  input  logic                 pop,
  output foo_operand_t         head,
  output logic                 head_valid,
  output logic [FOO_CNT_W-1:0] count
);

  foo_operand_t         mem [FOO_DEPTH];
  logic                 wr_idx;
  logic                 rd_idx;
  logic                 do_push;
  logic                 do_pop;
  logic [FOO_CNT_W-1:0] count_nxt;

  // Guard against push-when-full / pop-when-empty even though the top never requests them.
  always_comb begin
    do_push   = push && (count != FOO_CNT_W'(FOO_DEPTH));
    do_pop    = pop && head_valid;
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + FOO_CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - FOO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FOO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_idx     <= 1'b0;
      rd_idx     <= 1'b0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (do_pop) begin
        rd_idx <= ~rd_idx;
      end
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
    end
  end

  assign head = mem[rd_idx];

endmodule

// File: rtl/foo_operand_arbiter.sv
// Round-robin collector of operand pairs from three requesters, buffered in a 2-entry FIFO
// so downstream handshake_ready never reaches the requester readies combinationally.
module foo_operand_arbiter
  import foo_pkg::*;
(
  input  logic                 CLK,
  input  logic                 ASYNCRESET,
  input  logic                 handshake_arr_0_valid,
  output logic                 handshake_arr_0_ready,
  input  logic [FOO_WIDTH-1:0] req_0_in1,
  input  logic [FOO_WIDTH-1:0] req_0_in2,
  input  logic                 handshake_arr_1_valid,
  output logic                 handshake_arr_1_ready,
  input  logic [FOO_WIDTH-1:0] req_1_in1,
  input  logic [FOO_WIDTH-1:0] req_1_in2,
  input  logic                 handshake_arr_2_valid,
  output logic                 handshake_arr_2_ready,
  input  logic [FOO_WIDTH-1:0] req_2_in1,
  input  logic [FOO_WIDTH-1:0] req_2_in2,
  output logic                 handshake_valid,
  input  logic                 handshake_ready,
  output logic [FOO_WIDTH-1:0] in1,
  output logic [FOO_WIDTH-1:0] in2,
  output logic [1:0]           src,
  output logic [1:0]           occupancy
);

  localparam int unsigned WIDTH = FOO_WIDTH;
  localparam int unsigned NREQ  = FOO_NREQ;
  localparam int unsigned DEPTH = FOO_DEPTH;
  localparam int unsigned PTR_W = FOO_SRC_W;

  logic [NREQ-1:0]      valid_vec;
  logic [NREQ-1:0]      ready_vec;
  logic [WIDTH-1:0]     in1_vec [NREQ];
  logic [WIDTH-1:0]     in2_vec [NREQ];

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     win;
  logic [PTR_W:0]       scan_sum;
  logic [PTR_W-1:0]     scan_idx;
  logic                 any_valid;
  logic                 can_push;
  logic                 transfer;
  logic                 pop;

  foo_operand_t         push_data;
  foo_operand_t         head;
  logic                 head_valid;
  logic [FOO_CNT_W-1:0] count;

  assign valid_vec  = {handshake_arr_2_valid, handshake_arr_1_valid, handshake_arr_0_valid};
  assign in1_vec[0] = req_0_in1;
  assign in1_vec[1] = req_1_in1;
  assign in1_vec[2] = req_2_in1;
  assign in2_vec[0] = req_0_in2;
  assign in2_vec[1] = req_1_in2;
  assign in2_vec[2] = req_2_in2;

  // Scan ptr, ptr+1, ... mod NREQ; the first valid requester wins.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (scan_sum >= (PTR_W + 1)'(NREQ)) begin
        scan_sum = scan_sum - (PTR_W + 1)'(NREQ);
      end
      scan_idx = PTR_W'(scan_sum);
      if (!any_valid && valid_vec[scan_idx]) begin
        any_valid = 1'b1;
        win       = scan_idx;
      end
    end
  end

  // Accept depends on registered count only; readies are held low throughout reset.
  always_comb begin
    can_push           = (count < FOO_CNT_W'(DEPTH));
    transfer           = can_push && any_valid && !ASYNCRESET;
    ready_vec          = '0;
    ready_vec[win]     = transfer;
    push_data.src      = win;
    push_data.in1      = in1_vec[win];
    push_data.in2      = in2_vec[win];
  end

  assign handshake_arr_0_ready = ready_vec[0];
  assign handshake_arr_1_ready = ready_vec[1];
  assign handshake_arr_2_ready = ready_vec[2];

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= foo_wrap_inc(win);
    end
  end

  assign pop = head_valid && handshake_ready;

  foo_fifo2 u_fifo (
    .clk        (CLK),
    .rst        (ASYNCRESET),
    .push       (transfer),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign handshake_valid = head_valid;
  assign in1             = head.in1;
  assign in2             = head.in2;
  assign src             = head.src;
  assign occupancy       = count;

endmodule

// File: tb/tb_foo_operand_arbiter.sv
// Bench for foo_operand_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_foo_operand_arbiter;
  import foo_pkg::*;

  logic       CLK = 1'b0;
  logic       rst;
  logic [2:0] valid;
  logic [4:0] a1 [3];
  logic [4:0] a2 [3];
  logic       dn_ready;

  logic       rdy0, rdy1, rdy2;
  logic       hv;
  logic [4:0] o_in1, o_in2;
  logic [1:0] o_src, o_occ;
  logic [2:0] rdy;

  foo_operand_t q[$];
  int mptr;
  int n_tests;
  int n_fail;

  always #5 CLK = ~CLK;

  assign rdy = {rdy2, rdy1, rdy0};

  foo_operand_arbiter dut (
    .CLK                   (CLK),
    .ASYNCRESET            (rst),
    .handshake_arr_0_valid (valid[0]),
    .handshake_arr_0_ready (rdy0),
    .req_0_in1             (a1[0]),
    .req_0_in2             (a2[0]),
    .handshake_arr_1_valid (valid[1]),
    .handshake_arr_1_ready (rdy1),
    .req_1_in1             (a1[1]),
    .req_1_in2             (a2[1]),
    .handshake_arr_2_valid (valid[2]),
    .handshake_arr_2_ready (rdy2),
    .req_2_in1             (a1[2]),
    .req_2_in2             (a2[2]),
    .handshake_valid       (hv),
    .handshake_ready       (dn_ready),
    .in1                   (o_in1),
    .in2                   (o_in2),
    .src                   (o_src),
    .occupancy             (o_occ)
  );

  // Expected one-hot grant: first valid requester from mptr, only when there is room.
  function automatic logic [2:0] exp_ready();
    logic [2:0] r;
    r = '0;
    if (!rst && q.size() < 2) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (mptr + k) % 3;
        if (valid[idx] && r == 3'b000) r[idx] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    mptr = 0;
  endtask

  // Advance one clock, applying the transfers the model predicts for this edge.
  task automatic tick();
    logic [2:0]   r;
    bit           do_pop;
    foo_operand_t e;
    r      = exp_ready();
    do_pop = (q.size() > 0) && dn_ready && !rst;
    @(posedge CLK);
    if (do_pop) q.delete(0);
    for (int i = 0; i < 3; i++) begin
      if (r[i]) begin
        e.src  = 2'(i);
        e.in1  = a1[i];
        e.in2  = a2[i];
        q.push_back(e);
        mptr = (i + 1) % 3;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({hv, o_in1, o_in2, o_src, o_occ, rdy} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got hv=%b in1=%0d in2=%0d src=%0d occ=%0d rdy=%b exp all 0",
               hv, o_in1, o_in2, o_src, o_occ, rdy);
    end
    @(posedge CLK);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      #2;
      n_tests++;
      if (rdy !== 3'b000 || hv !== 1'b0 || o_occ !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got rdy=%b hv=%b occ=%0d exp 000/0/0", c, rdy, hv, o_occ);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_r;
    logic [1:0] exp_s;
    for (int i = 0; i < 3; i++) begin
      a1[i] = 5'(2 * i + 1);
      a2[i] = 5'(2 * i + 2);
    end
    valid    = 3'b111;
    dn_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #2;
      exp_r = 3'b001 << (c % 3);
      n_tests++;
      if (rdy !== exp_r) begin
        n_fail++;
        $display("FAIL rr_grant c=%0d got=%b exp=%b", c, rdy, exp_r);
      end
      if (c > 0) begin
        exp_s = 2'((c - 1) % 3);
        n_tests++;
        if (hv !== 1'b1 || o_src !== exp_s || o_in1 !== 5'(2 * exp_s + 1) ||
            o_in2 !== 5'(2 * exp_s + 2) || o_occ !== 2'd1) begin
          n_fail++;
          $display("FAIL rr_head c=%0d got hv=%b src=%0d in=(%0d,%0d) occ=%0d exp src=%0d occ=1",
                   c, hv, o_src, o_in1, o_in2, o_occ, exp_s);
        end
      end
      tick();
    end
    valid = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_full();
    dn_ready = 1'b0;
    valid    = 3'b010;
    a1[1]    = 5'd7;
    a2[1]    = 5'd9;
    #2;
    n_tests++;
    if (rdy !== 3'b010) begin
      n_fail++;
      $display("FAIL full_first_grant got=%b exp=010", rdy);
    end
    tick();
    a1[1] = 5'd10;
    a2[1] = 5'd11;
    #2;
    n_tests++;
    if (rdy !== 3'b010 || o_occ !== 2'd1 || o_in1 !== 5'd7 || o_in2 !== 5'd9 || o_src !== 2'd1) begin
      n_fail++;
      $display("FAIL full_second got rdy=%b occ=%0d head=(%0d,%0d,%0d) exp 010/1/(7,9,1)",
               rdy, o_occ, o_in1, o_in2, o_src);
    end
    tick();
    a1[1] = 5'd12;
    a2[1] = 5'd13;
    #2;
    n_tests++;
    if (rdy !== 3'b000 || o_occ !== 2'd2 || hv !== 1'b1) begin
      n_fail++;
      $display("FAIL full_stalled got rdy=%b occ=%0d hv=%b exp 000/2/1", rdy, o_occ, hv);
    end
    dn_ready = 1'b1;
    #1;
    n_tests++;
    if (rdy !== 3'b000) begin
      n_fail++;
      $display("FAIL full_no_bypass got rdy=%b exp=000", rdy);
    end
    tick();
    dn_ready = 1'b0;
    #2;
    n_tests++;
    if (o_occ !== 2'd1 || o_in1 !== 5'd10 || o_in2 !== 5'd11 || o_src !== 2'd1 || rdy !== 3'b010) begin
      n_fail++;
      $display("FAIL full_after_pop got occ=%0d head=(%0d,%0d,%0d) rdy=%b exp 1/(10,11,1)/010",
               o_occ, o_in1, o_in2, o_src, rdy);
    end
    valid    = 3'b000;
    dn_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_skip();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    dn_ready = 1'b1;
    valid    = 3'b100;
    #1;
    n_tests++;
    if (rdy !== 3'b100) begin
      n_fail++;
      $display("FAIL skip_only2 got=%b exp=100", rdy);
    end
    tick();
    valid = 3'b101;
    #2;
    n_tests++;
    if (rdy !== 3'b001) begin
      n_fail++;
      $display("FAIL skip_wrap_to0 got=%b exp=001", rdy);
    end
    tick();
    #2;
    n_tests++;
    if (rdy !== 3'b100) begin
      n_fail++;
      $display("FAIL skip_then2 got=%b exp=100", rdy);
    end
    tick();
    valid = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    dn_ready = 1'b0;
    valid    = 3'b011;
    for (int i = 0; i < 3; i++) begin
      a1[i] = 5'($urandom_range(1, 31));
      a2[i] = 5'($urandom_range(1, 31));
    end
    tick();
    tick();
    #2;
    n_tests++;
    if (o_occ !== 2'd2 || rdy !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_prefill got occ=%0d rdy=%b exp 2/000", o_occ, rdy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({hv, o_in1, o_in2, o_src, o_occ, rdy} !== '0) begin
      n_fail++;
      $display("FAIL mid_async got hv=%b in=(%0d,%0d) src=%0d occ=%0d rdy=%b exp all 0",
               hv, o_in1, o_in2, o_src, o_occ, rdy);
    end
    model_reset();
    tick();
    n_tests++;
    if ({hv, o_occ, rdy} !== '0) begin
      n_fail++;
      $display("FAIL mid_hold got hv=%b occ=%0d rdy=%b exp 0/0/000", hv, o_occ, rdy);
    end
    rst   = 1'b0;
    valid = 3'b110;
    #2;
    n_tests++;
    if (rdy !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_first_grant got=%b exp=010", rdy);
    end
    tick();
    #2;
    n_tests++;
    if (hv !== 1'b1 || o_src !== 2'd1 || o_in1 !== a1[1] || o_in2 !== a2[1]) begin
      n_fail++;
      $display("FAIL mid_head got hv=%b src=%0d in=(%0d,%0d) exp 1/1/(%0d,%0d)",
               hv, o_src, o_in1, o_in2, a1[1], a2[1]);
    end
    valid    = 3'b000;
    dn_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_held_head();
    dn_ready = 1'b0;
    valid    = 3'b001;
    a1[0]    = 5'd31;
    a2[0]    = 5'd0;
    #2;
    n_tests++;
    if (rdy !== exp_ready()) begin
      n_fail++;
      $display("FAIL held_grant got=%b exp=%b", rdy, exp_ready());
    end
    tick();
    valid = 3'b000;
    a1[0] = 5'd3;
    a2[0] = 5'd3;
    for (int c = 0; c < 4; c++) begin
      #2;
      n_tests++;
      if (hv !== 1'b1 || o_in1 !== 5'd31 || o_in2 !== 5'd0 || o_src !== 2'd0 || o_occ !== 2'd1) begin
        n_fail++;
        $display("FAIL held_stable c=%0d got hv=%b head=(%0d,%0d,%0d) occ=%0d exp 1/(31,0,0)/1",
                 c, hv, o_in1, o_in2, o_src, o_occ);
      end
      tick();
    end
    dn_ready = 1'b1;
    tick();
    dn_ready = 1'b0;
    #2;
    n_tests++;
    if (hv !== 1'b0 || o_occ !== 2'd0) begin
      n_fail++;
      $display("FAIL held_single_pop got hv=%b occ=%0d exp 0/0", hv, o_occ);
    end
    tick();
  endtask

  task automatic test_random();
    logic [2:0] exp_r;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
      end
      valid    = 3'($urandom_range(0, 7));
      dn_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) begin
        a1[i] = 5'($urandom);
        a2[i] = 5'($urandom);
      end
      #1;
      exp_r = exp_ready();
      n_tests++;
      if (rdy !== exp_r || hv !== (q.size() != 0) || o_occ !== 2'(q.size())) begin
        n_fail++;
        $display("FAIL rand_ctrl c=%0d got rdy=%b hv=%b occ=%0d exp rdy=%b occ=%0d",
                 c, rdy, hv, o_occ, exp_r, q.size());
      end
      if (q.size() != 0) begin
        n_tests++;
        if (o_in1 !== q[0].in1 || o_in2 !== q[0].in2 || o_src !== q[0].src) begin
          n_fail++;
          $display("FAIL rand_head c=%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)",
                   c, o_in1, o_in2, o_src, q[0].in1, q[0].in2, q[0].src);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid    = 3'b000;
    dn_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1[i] = '0;
      a2[i] = '0;
    end
    model_reset();
    test_reset();
    test_round_robin();
    test_full();
    test_skip();
    test_reset_mid();
    test_held_head();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
